// File: rtl/seg_pkg.sv
// Shared 7-segment definitions.
// Provides the hex glyph constants (bit0=a .. bit6=g, active-high), a lookup
// function used by seg_encoder, and the scan FSM state encodings.
package seg_pkg;

  localparam logic [6:0] Glyph0 = 7'h3f;
  localparam logic [6:0] Glyph1 = 7'h06;
  localparam logic [6:0] Glyph2 = 7'h5b;
  localparam logic [6:0] Glyph3 = 7'h4f;
  localparam logic [6:0] Glyph4 = 7'h66;
  localparam logic [6:0] Glyph5 = 7'h6d;
  localparam logic [6:0] Glyph6 = 7'h7d;
  localparam logic [6:0] Glyph7 = 7'h07;
  localparam logic [6:0] Glyph8 = 7'h7f;
  localparam logic [6:0] Glyph9 = 7'h6f;
  localparam logic [6:0] GlyphA = 7'h77;
  localparam logic [6:0] GlyphB = 7'h7c;
  localparam logic [6:0] GlyphC = 7'h39;
  localparam logic [6:0] GlyphD = 7'h5e;
  localparam logic [6:0] GlyphE = 7'h79;
  localparam logic [6:0] GlyphF = 7'h71;

  // Leftmost entry is index 15.
  localparam logic [15:0][6:0] Glyphs = {
    GlyphF, GlyphE, GlyphD, GlyphC, GlyphB, GlyphA, Glyph9, Glyph8,
    Glyph7, Glyph6, Glyph5, Glyph4, Glyph3, Glyph2, Glyph1, Glyph0
  };

  // Scan FSM states.
  localparam logic StShow  = 1'b0;
  localparam logic StBlank = 1'b1;

  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return Glyphs[value];
  endfunction

endpackage

// File: rtl/segment_scan_ctrl_if.sv
// Write/commit port of the segment scan controller.
// master: system side (drives wr_valid, wr_idx, wr_val, commit)
// slave:  controller side (drives wr_ready, commit_pending)
interface segment_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic            wr_valid;
  logic            wr_ready;
  logic [IdxW-1:0] wr_idx;
  logic [3:0]      wr_val;
  logic            commit;
  logic            commit_pending;

  modport master (
    output wr_valid, wr_idx, wr_val, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_idx, wr_val, commit,
    output wr_ready, commit_pending
  );

endinterface

// File: rtl/seg_encoder.sv
// Combinational hex to 7-segment lookup (bit0=a .. bit6=g, active-high).
// value_i   : 4-bit hex value
// segment_o : segment pattern
module seg_encoder
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] segment_o
);

  always_comb begin
    segment_o = seg_encode(value_i);
  end

endmodule

// File: rtl/segment_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digit storage.
// clk, rst     : clock and synchronous active-high reset
// wr_if        : write/commit port (slave side)
// segment      : segment bus, bit0=a .. bit6=g, active-high
// digit_en     : one-hot digit enable, all-zero during blank gaps
// frame_start  : one-cycle pulse on the first SHOW cycle of digit 0
module segment_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned ON_CYCLES    = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  segment_scan_ctrl_if.slave    wr_if,
  output logic [6:0]            segment,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_start
);

  localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntMax  = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] OnLoad    = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLoad = (BLANK_CYCLES > 0) ? CntW'(BLANK_CYCLES - 1) : '0;

  logic                        state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;      // cycles left in current state, minus one
  logic [IdxW-1:0]             cur_q, cur_d;
  logic                        pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]  active_q, active_d;
  logic [6:0]                  segment_q, segment_d;
  logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
  logic                        frame_start_q, frame_start_d;
  logic                        advance;
  logic [3:0]                  show_val;
  logic [6:0]                  show_glyph;

  // Scan sequencing. Reset parks the FSM on the last cycle of a blank after the
  // final digit, so the first edge out of reset enters SHOW of digit 0 as a
  // normal frame start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    advance = 1'b0;

    if (state_q == StShow) begin
      if (cnt_q == '0) begin
        if (BLANK_CYCLES == 0) begin
          advance = 1'b1;
        end else begin
          state_d = StBlank;
          cnt_d   = BlankLoad;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        advance = 1'b1;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    if (advance) begin
      state_d = StShow;
      cnt_d   = OnLoad;
      cur_d   = (cur_q == LastIdx) ? '0 : cur_q + IdxW'(1);
    end

    frame_start_d = advance && (cur_d == '0);
  end

  // Register files and commit handshake. Writes are blocked while a transfer
  // is outstanding, so the snapshot taken at the frame edge is stable.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (wr_if.wr_valid && !pending_q && (32'(wr_if.wr_idx) < NUM_DIGITS)) begin
      shadow_d[wr_if.wr_idx] = wr_if.wr_val;
    end

    if (pending_q) begin
      // pending_q is only set after the commit edge, so this is strictly later.
      if (frame_start_d) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (wr_if.commit) begin
      pending_d = 1'b1;
    end
  end

  // Outputs are registered from next-state so digit 0 of a transfer frame
  // already shows the new contents.
  assign show_val = active_d[cur_d];

  seg_encoder u_seg_encoder (
    .value_i   (show_val),
    .segment_o (show_glyph)
  );

  always_comb begin
    digit_en_d = '0;
    segment_d  = '0;
    if (state_d == StShow) begin
      digit_en_d[cur_d] = 1'b1;
      segment_d         = show_glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBlank;
      cnt_q         <= '0;
      cur_q         <= LastIdx;
      pending_q     <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      segment_q     <= '0;
      digit_en_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_q         <= cur_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      segment_q     <= segment_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segment              = segment_q;
  assign digit_en             = digit_en_q;
  assign frame_start          = frame_start_q;
  assign wr_if.wr_ready       = !pending_q;
  assign wr_if.commit_pending = pending_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
module tb_segment_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] en_a;
  logic [2:0] en_b;
  logic       fs_a, fs_b;

  segment_scan_ctrl_if #(.NUM_DIGITS(4)) if_a ();
  segment_scan_ctrl_if #(.NUM_DIGITS(3)) if_b ();

  segment_scan_ctrl #(.NUM_DIGITS(4), .ON_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .wr_if       (if_a),
    .segment     (seg_a),
    .digit_en    (en_a),
    .frame_start (fs_a)
  );

  segment_scan_ctrl #(.NUM_DIGITS(3), .ON_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .wr_if       (if_b),
    .segment     (seg_b),
    .digit_en    (en_b),
    .frame_start (fs_b)
  );

  logic [6:0] glyph [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                             7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    bit         disp;
    logic [3:0] en;
    logic [6:0] seg;
    logic       fs;
    logic       pend;
    logic       rdy;
  } exp_t;

  typedef struct {
    int         cyc;
    bit         wv;
    int         idx;
    int         val;
    bit         cm;
    logic [3:0] en;
    logic [6:0] seg;
    logic       fs;
    logic       pend;
    logic       rdy;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  // Bench-side model of the shadow file and pending flag for DUT A.
  int sh_m [4];
  bit pend_m;
  int clear_at;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void push_sb(exp_t e);
    int i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endfunction

  function automatic void push_frame(int t, int v0, int v1, int v2, int v3);
    int   vals [4];
    exp_t e;
    vals = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) begin
      e = '{t + 10 * k, 1'b1, 4'(1 << k), glyph[vals[k]], (k == 0), 1'b0, 1'b0};
      push_sb(e);
      e = '{t + 10 * k + 8, 1'b1, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0};
      push_sb(e);
    end
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("onehot_a", 32'($countones(en_a) <= 1), 32'd1);
    chk("onehot_b", 32'($countones(en_b) <= 1), 32'd1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("sb_cycle", cyc, e.cyc);
      if (e.disp) begin
        chk("sb_digit_en", en_a, e.en);
        chk("sb_segment", seg_a, e.seg);
        chk("sb_frame_start", fs_a, e.fs);
      end else begin
        chk("sb_pending", if_a.commit_pending, e.pend);
        chk("sb_ready", if_a.wr_ready, e.rdy);
      end
    end
  endtask

  // Drives DUT A inputs for the next edge and records the expected effects.
  task automatic drive_a(bit wv, int idx, int val, bit cm);
    int   t;
    exp_t e;
    if (pend_m && cyc >= clear_at) pend_m = 1'b0;
    if_a.wr_valid = wv;
    if_a.wr_idx   = 2'(idx);
    if_a.wr_val   = 4'(val);
    if_a.commit   = cm;
    if (wv && !pend_m) sh_m[idx] = val;
    if (cm && !pend_m) begin
      t        = ((cyc + 1) / 40 + 1) * 40;
      pend_m   = 1'b1;
      clear_at = t;
      e = '{cyc + 1, 1'b0, 4'h0, 7'h00, 1'b0, 1'b1, 1'b0};
      push_sb(e);
      e = '{t, 1'b0, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1};
      push_sb(e);
      push_frame(t, sh_m[0], sh_m[1], sh_m[2], sh_m[3]);
    end
  endtask

  task automatic chk_out_a(string tag, logic [3:0] en, logic [6:0] seg, logic fs,
                           logic pend, logic rdy);
    chk({tag, "_digit_en"}, en_a, en);
    chk({tag, "_segment"}, seg_a, seg);
    chk({tag, "_frame_start"}, fs_a, fs);
    chk({tag, "_pending"}, if_a.commit_pending, pend);
    chk({tag, "_ready"}, if_a.wr_ready, rdy);
  endtask

  initial begin
    logic [2:0] exp_en_b;

    // cyc, wv, idx, val, cm | en, seg, fs, pend, rdy
    vt.push_back('{  0, 0, 0, 0,   0, 4'h1, 7'h3f, 1, 0, 1});
    vt.push_back('{  1, 1, 0, 1,   0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  2, 1, 1, 2,   0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  3, 1, 2, 3,   0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  4, 1, 3, 10,  0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  5, 0, 0, 0,   0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  7, 0, 0, 0,   0, 4'h1, 7'h3f, 0, 0, 1});
    vt.push_back('{  8, 0, 0, 0,   0, 4'h0, 7'h00, 0, 0, 1});
    vt.push_back('{  9, 0, 0, 0,   0, 4'h0, 7'h00, 0, 0, 1});
    vt.push_back('{ 10, 0, 0, 0,   0, 4'h2, 7'h3f, 0, 0, 1});
    vt.push_back('{ 18, 0, 0, 0,   0, 4'h0, 7'h00, 0, 0, 1});
    vt.push_back('{ 20, 0, 0, 0,   0, 4'h4, 7'h3f, 0, 0, 1});
    vt.push_back('{ 30, 0, 0, 0,   0, 4'h8, 7'h3f, 0, 0, 1});
    vt.push_back('{ 39, 0, 0, 0,   0, 4'h0, 7'h00, 0, 0, 1});
    vt.push_back('{ 40, 0, 0, 0,   0, 4'h1, 7'h3f, 1, 0, 1});
    vt.push_back('{ 80, 0, 0, 0,   0, 4'h1, 7'h3f, 1, 0, 1});
    vt.push_back('{110, 0, 0, 0,   0, 4'h8, 7'h3f, 0, 0, 1});
    vt.push_back('{120, 0, 0, 0,   0, 4'h1, 7'h3f, 1, 0, 1});
    vt.push_back('{135, 0, 0, 0,   1, 4'h2, 7'h3f, 0, 0, 1});
    vt.push_back('{136, 0, 0, 0,   0, 4'h2, 7'h3f, 0, 1, 0});
    vt.push_back('{140, 1, 1, 15,  0, 4'h4, 7'h3f, 0, 1, 0});
    vt.push_back('{141, 0, 0, 0,   0, 4'h4, 7'h3f, 0, 1, 0});
    vt.push_back('{150, 0, 0, 0,   0, 4'h8, 7'h3f, 0, 1, 0});
    vt.push_back('{159, 0, 0, 0,   0, 4'h0, 7'h00, 0, 1, 0});
    vt.push_back('{160, 0, 0, 0,   0, 4'h1, 7'h06, 1, 0, 1});
    vt.push_back('{170, 0, 0, 0,   0, 4'h2, 7'h5b, 0, 0, 1});
    vt.push_back('{180, 0, 0, 0,   0, 4'h4, 7'h4f, 0, 0, 1});
    vt.push_back('{190, 0, 0, 0,   0, 4'h8, 7'h77, 0, 0, 1});
    vt.push_back('{205, 1, 2, 5,   1, 4'h1, 7'h06, 0, 0, 1});
    vt.push_back('{206, 0, 0, 0,   0, 4'h1, 7'h06, 0, 1, 0});
    vt.push_back('{210, 1, 1, 15,  0, 4'h2, 7'h5b, 0, 1, 0});
    vt.push_back('{211, 0, 0, 0,   0, 4'h2, 7'h5b, 0, 1, 0});
    vt.push_back('{215, 0, 0, 0,   1, 4'h2, 7'h5b, 0, 1, 0});
    vt.push_back('{216, 0, 0, 0,   0, 4'h2, 7'h5b, 0, 1, 0});
    vt.push_back('{240, 0, 0, 0,   0, 4'h1, 7'h06, 1, 0, 1});
    vt.push_back('{250, 0, 0, 0,   0, 4'h2, 7'h5b, 0, 0, 1});
    vt.push_back('{260, 0, 0, 0,   0, 4'h4, 7'h6d, 0, 0, 1});
    vt.push_back('{270, 1, 3, 4,   0, 4'h8, 7'h77, 0, 0, 1});
    vt.push_back('{271, 0, 0, 0,   0, 4'h8, 7'h77, 0, 0, 1});
    vt.push_back('{279, 0, 0, 0,   1, 4'h0, 7'h00, 0, 0, 1});
    vt.push_back('{280, 0, 0, 0,   0, 4'h1, 7'h06, 1, 1, 0});
    vt.push_back('{310, 0, 0, 0,   0, 4'h8, 7'h77, 0, 1, 0});
    vt.push_back('{319, 0, 0, 0,   0, 4'h0, 7'h00, 0, 1, 0});
    vt.push_back('{320, 0, 0, 0,   0, 4'h1, 7'h06, 1, 0, 1});
    vt.push_back('{350, 0, 0, 0,   0, 4'h8, 7'h66, 0, 0, 1});
    vt.push_back('{362, 1, 0, 8,   0, 4'h1, 7'h06, 0, 0, 1});
    vt.push_back('{363, 0, 0, 0,   0, 4'h1, 7'h06, 0, 0, 1});
    vt.push_back('{365, 0, 0, 0,   1, 4'h1, 7'h06, 0, 0, 1});
    vt.push_back('{366, 0, 0, 0,   0, 4'h1, 7'h06, 0, 1, 0});
    vt.push_back('{384, 0, 0, 0,   0, 4'h4, 7'h6d, 0, 1, 0});

    if_a.wr_valid = 1'b0; if_a.wr_idx = '0; if_a.wr_val = '0; if_a.commit = 1'b0;
    if_b.wr_valid = 1'b0; if_b.wr_idx = '0; if_b.wr_val = '0; if_b.commit = 1'b0;
    sh_m   = '{0, 0, 0, 0};
    pend_m = 1'b0;
    clear_at = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;

    // Reset state of DUT A.
    repeat (3) tick();
    chk_out_a("reset", 4'h0, 7'h00, 1'b0, 1'b0, 1'b1);
    rst_a = 1'b0;
    cyc   = -1;

    // Main table: check outputs at each listed cycle, then drive that row's inputs.
    foreach (vt[i]) begin
      while (cyc < vt[i].cyc) tick();
      chk_out_a($sformatf("vec%0d", vt[i].cyc), vt[i].en, vt[i].seg, vt[i].fs,
                vt[i].pend, vt[i].rdy);
      drive_a(vt[i].wv, vt[i].idx, vt[i].val, vt[i].cm);
    end

    // Reset mid-frame (cycle 25 of frame 9) with a commit outstanding.
    rst_a = 1'b1;
    tick();
    chk_out_a("midrst", 4'h0, 7'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out_a("midrst_hold", 4'h0, 7'h00, 1'b0, 1'b0, 1'b1);
    rst_a = 1'b0;
    sb.delete();
    sh_m     = '{0, 0, 0, 0};
    pend_m   = 1'b0;
    clear_at = 0;
    cyc      = -1;
    push_frame(0, 0, 0, 0, 0);
    tick();
    chk_out_a("post_rst", 4'h1, 7'h3f, 1'b1, 1'b0, 1'b1);
    // Committing now must expose the cleared shadow, not the pre-reset writes.
    while (cyc < 5) tick();
    drive_a(0, 0, 0, 1);
    tick();
    drive_a(0, 0, 0, 0);
    while (cyc < 80) tick();
    chk("sb_drained", sb.size(), 0);

    // DUT B: 3 digits, ON=1, no blank gap.
    tick();
    chk("b_reset_en", en_b, 3'b000);
    chk("b_reset_seg", seg_b, 7'h00);
    rst_b = 1'b0;
    for (int n = 0; n < 18; n++) begin
      tick();
      exp_en_b = 3'b001 << (n % 3);
      chk($sformatf("b_en_%0d", n), en_b, exp_en_b);
      chk($sformatf("b_fs_%0d", n), fs_b, (n % 3 == 0));
      chk($sformatf("b_seg_%0d", n), seg_b, (n >= 12 && n % 3 == 1) ? 7'h6f : 7'h3f);
      chk($sformatf("b_pend_%0d", n), if_b.commit_pending, (n == 11));
      if_b.wr_valid = (n == 9 || n == 10);
      if_b.wr_idx   = (n == 9) ? 2'd3 : 2'd1;   // index 3 is out of range and dropped
      if_b.wr_val   = (n == 9) ? 4'h8 : 4'h9;
      if_b.commit   = (n == 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_scan_ctrl.md
# segment_scan_ctrl

Time-multiplexing controller that shares one 7-segment bus between NUM_DIGITS common-cathode digits. Holds a double-buffered digit register file written through a valid/ready port and scans the digits with a fixed on-time plus an anti-ghosting blank gap. New data is committed atomically at a frame boundary. Sits between the system write interface and the display pins; `segment` has the same bit order and encoding as `segment_display`.

## Interface
Parameters:
- NUM_DIGITS, 4 — digits scanned (2..8)
- ON_CYCLES, 8 — clocks each digit is driven (≥1)
- BLANK_CYCLES, 2 — clocks of all-off gap after each digit (0 = no gap)

Ports:
- clk  in  1  — the only clock
- rst  in  1  — synchronous, active-high reset
- wr_valid  in  1  — write request
- wr_ready  out  1  — write accepted when high with wr_valid
- wr_idx  in  $clog2(NUM_DIGITS)  — target digit
- wr_val  in  4  — hex value 0..15
- commit  in  1  — request shadow→active transfer
- commit_pending  out  1  — commit requested, not yet transferred
- segment  out  7  — bit0=a … bit6=g, active-high
- digit_en  out  NUM_DIGITS  — one-hot digit enable, active-high
- frame_start  out  1  — one-cycle pulse on first SHOW cycle of digit 0

## Operation
- Two register files: shadow[] (written by port) and active[] (displayed); both reset to 0.
- Write: accepted when wr_valid && wr_ready; shadow[wr_idx] <= wr_val. wr_idx ≥ NUM_DIGITS: accepted, dropped.
- wr_ready = !commit_pending (shadow frozen while a transfer is outstanding).
- commit with commit_pending=0 sets commit_pending; commit while pending is ignored. Write and commit in the same cycle: write lands, then is included in the transfer.
- Transfer: on the first frame-start edge strictly after the commit edge, active[] <= shadow[], commit_pending <= 0; digit 0 of that frame already shows new data.
- FSM states: SHOW, BLANK. SHOW: digit_en = one-hot(cur), segment = encode(active[cur]); lasts ON_CYCLES. BLANK: digit_en=0, segment=0; lasts BLANK_CYCLES, skipped if 0. After BLANK (or SHOW if skipped), cur increments; NUM_DIGITS-1 wraps to 0 = frame start.
- Encoding (g..a hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

## Timing
- All outputs registered. During reset and the cycle after it: segment=0, digit_en=0, frame_start=0, commit_pending=0, wr_ready=1.
- Cycle 0 = first edge with rst=0: SHOW digit 0, frame_start=1.
- Defaults: digit k SHOW on cycles 10k..10k+7, BLANK on 10k+8..10k+9; frame period NUM_DIGITS·(ON_CYCLES+BLANK_CYCLES) = 40; frame_start at 0, 40, 80, ….
- Write-to-shadow latency 1 clk; commit_pending rises 1 clk after commit edge.
- rst mid-frame: next edge returns every register to reset values, pending commit and shadow contents discarded.
- digit_en never has more than one bit set; never changes in the same cycle as a nonzero segment change except at SHOW entry.

## Structure
- Package seg_pkg: glyph constants for 0..F, encode function, state enum {SHOW, BLANK}.
- Sub-module seg_encoder: combinational 4→7 lookup, shared with segment_display.
- Top holds counters, FSM, register files, handshake.

## Test plan
- Reset release, no writes -> cycle 0: digit_en=0001, segment=0x3F, frame_start=1; cycle 8: digit_en=0, segment=0; cycle 10: digit_en=0010.
- Write idx0..3 = 1,2,3,A, no commit -> display stays all 0x3F for 3 frames.
- Same writes, commit at cycle 15 -> commit_pending 1 from 16, wr_ready 0; at cycle 40: digit0=0x06, pending 0; cycle 70: digit3=0x77.
- Write idx2=5 and commit same cycle -> next frame digit2=0x6D; write attempted while pending -> wr_ready=0, shadow unchanged.
- BLANK_CYCLES=0, ON_CYCLES=1, NUM_DIGITS=3 -> digit_en 001,010,100 repeating, frame_start every 3 cycles.
- rst at cycle 25 with commit pending -> after release: pending 0, all digits 0x3F, frame restarts at digit 0.
